// File: rtl/text_row_fetcher.sv
// rtl/text_row_fetcher.sv - shares one glyph ROM across a text line by prefetching each row during h-blank
module text_row_fetcher #(
  parameter int NUM_CHARS  = 8,
  parameter int TEXT_X     = 192,
  parameter int TEXT_Y     = 208,
  parameter int SLOT_PITCH = 16,
  parameter int FETCH_X    = 640,
  parameter int V_LAST     = 524
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [9:0]             x,
  input  logic [9:0]             y,
  input  logic [NUM_CHARS*7-1:0] chars,
  output logic [10:0]            rom_addr,
  input  logic [7:0]             rom_data,
  output logic                   pixel_on,
  output logic                   busy,
  output logic                   overrun
);

  localparam int SW = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;
  localparam logic [SW-1:0] LAST_SLOT = SW'(NUM_CHARS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, SWAP} state_t;

  state_t                      state_q, state_d;
  logic [SW-1:0]               slot_q, slot_d;
  logic [9:0]                  x_prev_q;
  logic [NUM_CHARS*7-1:0]      snap_q, snap_d;
  logic [3:0]                  gr_q, gr_d;
  logic [10:0]                 rom_addr_q, rom_addr_d;
  logic [NUM_CHARS-1:0][7:0]   back_q, back_d;
  logic [NUM_CHARS-1:0][7:0]   front_q, front_d;
  logic                        pixel_on_q, pixel_on_d;

  logic                        start;
  logic                        in_band;
  logic [9:0]                  ty;
  logic [3:0]                  gr_now;
  logic [9:0]                  off;
  logic [9:0]                  col;
  logic [SW-1:0]               pix_slot;

  assign busy     = (state_q != IDLE);
  assign overrun  = start && busy;
  assign rom_addr = rom_addr_q;
  assign pixel_on = pixel_on_q;

  // Detect the first h-blank pixel of a line and decode which glyph row the next line needs
  always_comb begin
    start   = (x == 10'(FETCH_X)) && (x_prev_q != 10'(FETCH_X));
    ty      = (y == 10'(V_LAST)) ? 10'd0 : y + 10'd1;
    in_band = (ty >= 10'(TEXT_Y)) && (ty < 10'(TEXT_Y + 16));
    gr_now  = 4'(ty - 10'(TEXT_Y));
  end

  // Fetch sequencer: issue one ROM address per slot, collect data one clock later, then swap buffers
  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    snap_d     = snap_q;
    gr_d       = gr_q;
    rom_addr_d = rom_addr_q;
    back_d     = back_q;
    front_d    = front_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          snap_d = chars;
          gr_d   = gr_now;
          if (in_band) begin
            state_d    = ISSUE;
            slot_d     = '0;
            rom_addr_d = {chars[6:0], gr_now};
          end else begin
            front_d = '0;
          end
        end
      end
      ISSUE: begin
        if (slot_q != '0) begin
          back_d[slot_q - SW'(1)] = rom_data;
        end
        if (slot_q == LAST_SLOT) begin
          state_d = DRAIN;
        end else begin
          slot_d     = slot_q + SW'(1);
          rom_addr_d = {snap_q[7*int'(slot_d) +: 7], gr_q};
        end
      end
      DRAIN: begin
        back_d[LAST_SLOT] = rom_data;
        state_d           = SWAP;
      end
      SWAP: begin
        front_d = back_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pick the front-buffer bit under the current pixel; only slot columns 0..7 carry glyph bits
  always_comb begin
    pixel_on_d = 1'b0;
    off        = x - 10'(TEXT_X);
    col        = off % 10'(SLOT_PITCH);
    pix_slot   = SW'(off / 10'(SLOT_PITCH));
    if ((x >= 10'(TEXT_X)) && (off < 10'(NUM_CHARS * SLOT_PITCH)) && (col < 10'd8)) begin
      pixel_on_d = front_q[pix_slot][3'(10'd7 - col)];
    end
  end

  // State and datapath registers; reset abandons any fetch in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      slot_q     <= '0;
      x_prev_q   <= '0;
      snap_q     <= '0;
      gr_q       <= '0;
      rom_addr_q <= '0;
      back_q     <= '0;
      front_q    <= '0;
      pixel_on_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      x_prev_q   <= x;
      snap_q     <= snap_d;
      gr_q       <= gr_d;
      rom_addr_q <= rom_addr_d;
      back_q     <= back_d;
      front_q    <= front_d;
      pixel_on_q <= pixel_on_d;
    end
  end

endmodule

// File: tb/tb_text_row_fetcher.sv
// tb/tb_text_row_fetcher.sv - scoreboard bench for text_row_fetcher
module tb_text_row_fetcher;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  x, y;
  logic [55:0] chars;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data = 8'h00;
  logic        pixel_on, busy, overrun;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [10:0] addr;
    logic        ov;
  } bexp_t;

  bexp_t       bq[$];
  logic        pq[$];
  logic        pix_req;
  logic [7:0]  exp_front [8];
  logic [10:0] last_addr;

  always #5 clk = ~clk;

  text_row_fetcher dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .x        (x),
    .y        (y),
    .chars    (chars),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .pixel_on (pixel_on),
    .busy     (busy),
    .overrun  (overrun)
  );

  function automatic logic [7:0] rom_fn(input logic [10:0] a);
    return (a[10:4] == 7'h41) ? 8'h18 : a[7:0];
  endfunction

  always @(posedge clk) rom_data <= rom_fn(rom_addr);

  function automatic logic pix_model(input int xx);
    int off, s, c;
    if (xx < 192 || xx >= 320) return 1'b0;
    off = xx - 192;
    s   = off / 16;
    c   = off % 16;
    if (c >= 8) return 1'b0;
    return exp_front[s][7-c];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic monitor;
    logic  prev_req;
    bexp_t e;
    logic  pe;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (busy) begin
        if (bq.size() != 0) e = bq.pop_front();
        else e = 'x;
        chk("rom_addr", 32'(rom_addr), 32'(e.addr));
        chk("overrun", 32'(overrun), 32'(e.ov));
      end else begin
        chk("overrun_idle", 32'(overrun), 32'd0);
      end
      if (prev_req) begin
        if (pq.size() != 0) pe = pq.pop_front();
        else pe = 1'bx;
        chk("pixel_on", 32'(pixel_on), 32'(pe));
      end
      prev_req = pix_req;
    end
  endtask

  task automatic set_seq;
    for (int k = 0; k < 8; k++) chars[7*k +: 7] = 7'(8'h30 + k);
  endtask

  task automatic fetch(input logic [9:0] yy, input logic inb, input logic [3:0] gr,
                       input int ov_c, input int chg_c, input logic [55:0] chg_v);
    y = yy;
    x = 10'd639;
    step;
    if (inb) begin
      for (int k = 0; k < 8; k++) begin
        bq.push_back(bexp_t'({chars[7*k +: 7], gr, 1'(k + 1 == ov_c)}));
        exp_front[k] = rom_fn({chars[7*k +: 7], gr});
      end
      last_addr = {chars[55:49], gr};
      bq.push_back(bexp_t'({last_addr, 1'b0}));
      bq.push_back(bexp_t'({last_addr, 1'b0}));
    end else begin
      for (int k = 0; k < 8; k++) exp_front[k] = 8'h00;
    end
    x = 10'd640;
    step;
    for (int c = 1; c <= 12; c++) begin
      if (ov_c > 0 && c == ov_c - 1) x = 10'd0;
      if (ov_c > 0 && c == ov_c) x = 10'd640;
      if (c == chg_c) chars = chg_v;
      step;
    end
    x = 10'd641;
    chk("fetch_queue_drained", 32'(bq.size()), 32'd0);
    chk("busy_after_fetch", 32'(busy), 32'd0);
    chk("rom_addr_hold", 32'(rom_addr), 32'(last_addr));
  endtask

  task automatic sweep(input int x0, input int x1);
    for (int xx = x0; xx <= x1; xx++) begin
      x = 10'(xx);
      pix_req = 1'b1;
      pq.push_back(pix_model(xx));
      step;
    end
    pix_req = 1'b0;
    x = 10'd641;
    step;
    step;
    chk("pix_queue_drained", 32'(pq.size()), 32'd0);
  endtask

  initial begin
    reset_n   = 1'b1;
    x         = 10'd0;
    y         = 10'd0;
    chars     = {8{7'h41}};
    pix_req   = 1'b0;
    last_addr = 11'h000;
    for (int k = 0; k < 8; k++) exp_front[k] = 8'h00;
    fork
      monitor();
    join_none
    #2 reset_n = 1'b0;
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_pixel_on", 32'(pixel_on), 32'd0);
    chk("reset_rom_addr", 32'(rom_addr), 32'd0);
    chk("reset_overrun", 32'(overrun), 32'd0);
    step;
    step;
    reset_n = 1'b1;
    step;

    // 1: all 'A', row 0 of band; row 0x18 lights columns 3,4 of every slot
    fetch(10'd207, 1'b1, 4'd0, 0, 0, 56'h0);
    chk("t1_addr", 32'(rom_addr), 32'h410);
    y = 10'd208;
    sweep(184, 330);

    // 2: distinct codes per slot, glyph row 3
    set_seq();
    fetch(10'd210, 1'b1, 4'd3, 0, 0, 56'h0);
    chk("t2_addr", 32'(rom_addr), 32'h373);
    sweep(184, 330);

    // 3: next line outside the band, and frame wrap to y=0
    fetch(10'd223, 1'b0, 4'd0, 0, 0, 56'h0);
    chk("t3_addr_unchanged", 32'(rom_addr), 32'h373);
    sweep(184, 330);
    fetch(10'd524, 1'b0, 4'd0, 0, 0, 56'h0);
    chk("t3_wrap_addr_unchanged", 32'(rom_addr), 32'h373);
    sweep(184, 220);

    // 4: second start while busy at T+3
    chars = {8{7'h41}};
    fetch(10'd207, 1'b1, 4'd0, 3, 0, 56'h0);
    sweep(184, 230);

    // 5: reset asserted at T+4 of a fetch
    set_seq();
    y = 10'd210;
    x = 10'd639;
    step;
    for (int k = 0; k < 3; k++) bq.push_back(bexp_t'({chars[7*k +: 7], 4'd3, 1'b0}));
    x = 10'd640;
    step;
    step;
    step;
    step;
    reset_n = 1'b0;
    #1;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_rom_addr", 32'(rom_addr), 32'd0);
    chk("t5_pixel_on", 32'(pixel_on), 32'd0);
    x = 10'd641;
    step;
    step;
    reset_n = 1'b1;
    repeat (14) step;
    chk("t5_queue_drained", 32'(bq.size()), 32'd0);
    chk("t5_rom_addr_idle", 32'(rom_addr), 32'd0);
    last_addr = 11'h000;
    for (int k = 0; k < 8; k++) exp_front[k] = 8'h00;
    sweep(184, 330);

    // 6: chars change at T+2 must not disturb the snapshot; next line picks them up
    chars = {8{7'h41}};
    fetch(10'd207, 1'b1, 4'd0, 0, 2, {8{7'h5A}});
    chk("t6_addr_snapshot", 32'(rom_addr), 32'h410);
    fetch(10'd208, 1'b1, 4'd1, 0, 0, 56'h0);
    chk("t6_addr_new", 32'(rom_addr), 32'h5A1);
    sweep(184, 240);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
